program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time loader upstream of singleCycleCPU memory. Accepts a byte stream (text
//  segment, then data segment), packs bytes big-endian into 32-bit words, writes them
//  to the CPU's unified memory, then releases the CPU by asserting cpu_run. Replaces
//  bench-only $readmemh preload with synthesizable load path.
// PARAMETERS
//  TEXT_BASE   32'h0000_0000  byte address of first text word
//  DATA_BASE   32'h0000_2000  byte address of first data word; text upper bound (excl.)
//  DATA_LIMIT  32'h0000_4000  data upper bound (exclusive)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   stream byte valid
//  in_ready    out  1   loader can accept byte
//  in_data     in   8   stream byte
//  in_last     in   1   qualifies final byte of current segment
//  load_start  in   1   pulse: restart load (honoured only in DONE)
//  mem_we      out  1   one-cycle word write strobe
//  mem_addr    out  32  byte address of write, word-aligned
//  mem_wdata   out  32  word to write
//  cpu_run     out  1   high only in DONE; drives CPU reset release
//  pad_err     out  1   sticky: segment ended mid-word
//  ovf_err     out  1   sticky: segment exceeded its address window
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD_TEXT, in_ready=0 during reset then 1, mem_we=0,
//   mem_addr=0, mem_wdata=0, cpu_run=0, pad_err=0, ovf_err=0, byte_cnt=0,
//   wptr=TEXT_BASE. Reset mid-load discards partial word; no write issued.
//  States: LOAD_TEXT -> (accepted byte with in_last) -> LOAD_DATA, wptr=DATA_BASE;
//   LOAD_DATA -> (accepted byte with in_last) -> DONE; DONE -> (load_start) ->
//   LOAD_TEXT, wptr=TEXT_BASE, errors cleared. load_start ignored outside DONE.
//  in_ready=1 in LOAD_TEXT/LOAD_DATA, 0 in DONE. Byte accepted iff in_valid&in_ready.
//  Packing: byte k (k=0..3) of a word lands in mem_wdata[31-8k -: 8] (big-endian).
//  Write: cycle after 4th byte accepted (or after in_last byte), mem_we=1 for exactly
//   one cycle with mem_addr=wptr, mem_wdata=packed word; wptr+=4 in same cycle.
//   mem_addr/mem_wdata hold last value when mem_we=0.
//  Throughput: one byte/cycle, no backpressure in LOAD states; write register is
//   independent of accumulator, so a byte accepted in the write cycle is not lost.
//  Partial word: in_last with byte_cnt<3 -> unfilled low bytes zero, word written,
//   pad_err set. in_last on byte 3 is a clean boundary.
//  Empty segment: not representable (in_last needs a byte); a 1-byte segment is legal.
//  Window: text write with wptr>=DATA_BASE or data write with wptr>=DATA_LIMIT is
//   suppressed (mem_we stays 0), ovf_err set, bytes still accepted, state advances
//   normally on in_last. wptr arithmetic 32-bit, saturates (no wrap to 0).
//  cpu_run rises the cycle after final data write strobe (never overlaps mem_we);
//   falls the cycle after load_start accepted.
// TESTING
//  1) Text 8'h20,08,00,05 +last; data 8'hDE,AD,BE,EF +last -> writes
//     (0x0000,0x20080005),(0x2000,0xDEADBEEF); cpu_run=1 next cycle; errors 0.
//  2) 3 text words back-to-back, in_valid stuck 1 -> writes at 0x0,0x4,0x8, one strobe
//     per 4 cycles, no byte dropped, in_ready never low.
//  3) Text bytes 8'hAA,BB +last -> write 0xAABB0000 at 0x0, pad_err=1 and stays sticky.
//  4) DATA_BASE=32'h8, text of 12 bytes -> writes at 0x0,0x4 only; ovf_err=1;
//     data segment still starts at 0x8.
//  5) rst_n low after 2 bytes of word -> all outputs reset immediately, no mem_we;
//     reload from scratch writes first word to TEXT_BASE.
//  6) In DONE pulse load_start -> cpu_run=0 next cycle, in_ready=1, errors cleared,
//     next word lands at TEXT_BASE; load_start during LOAD_DATA has no effect.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader that sits in front of the CPU's unified memory. It takes a
//   byte stream holding the text segment followed by the data segment. Bytes are
//   packed big-endian into 32-bit words, and each word is written to its segment
//   window. When both segments are written, the CPU is released through cpu_run.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    stream byte valid
//   in_ready    loader can accept a byte (high in the two LOAD states)
//   in_data     stream byte
//   in_last     marks the final byte of the current segment
//   load_start  restart request, honoured only in DONE
//   mem_we      one-cycle word write strobe
//   mem_addr    word-aligned byte address of the write (held between strobes)
//   mem_wdata   packed word being written (held between strobes)
//   cpu_run     CPU release, high only once loading has finished
//   pad_err     sticky: a segment ended in the middle of a word
//   ovf_err     sticky: a segment ran past its address window
module program_loader #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE  = 32'h0000_2000,
  parameter logic [31:0] DATA_LIMIT = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        load_start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        pad_err,
  output logic        ovf_err
);

  typedef enum logic [1:0] {
    LOAD_TEXT = 2'd0,
    LOAD_DATA = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] wptr;
  logic [31:0] acc_p0;
  logic [31:0] packed_word;
  logic        accept;
  logic        word_done;
  logic        in_window;
  logic        restart;

  // Word pointer advance. The pointer sticks at the top aligned word and never
  // wraps to 0; a wrapped pointer would pass the window check and overwrite
  // low memory.
  function automatic logic [31:0] sat_add4(input logic [31:0] a);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'd4;
    return sum[32] ? 32'hFFFF_FFFC : sum[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_TEXT;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    restart     = 1'b0;
    in_window   = 1'b1;
    accept      = in_valid && in_ready;
    word_done   = accept && ((byte_cnt == 2'd3) || in_last);
    // Bytes after the incoming one are zero. A short final word is therefore
    // already zero-padded in its low bytes.
    packed_word = acc_p0;
    case (byte_cnt)
      2'd0:    packed_word = {in_data, 24'h0};
      2'd1:    packed_word = {acc_p0[31:24], in_data, 16'h0};
      2'd2:    packed_word = {acc_p0[31:16], in_data, 8'h0};
      default: packed_word = {acc_p0[31:8], in_data};
    endcase
    case (state)
      LOAD_TEXT: begin
        in_window = (wptr < DATA_BASE);
        if (accept && in_last) next_state = LOAD_DATA;
      end
      LOAD_DATA: begin
        in_window = (wptr < DATA_LIMIT);
        if (accept && in_last) next_state = DONE;
      end
      DONE: begin
        if (load_start) begin
          next_state = LOAD_TEXT;
          restart    = 1'b1;
        end
      end
      default: next_state = LOAD_TEXT;
    endcase
  end

  // Stage p0: byte accumulator. It holds data only; a stale value is never read,
  // because byte 0 of every word overwrites the whole register.
  always_ff @(posedge clk) begin
    if (accept) acc_p0 <= packed_word;
  end

  // Stage p1: write register and control. This register is loaded on the same
  // edge that clears byte_cnt. A byte arriving during the strobe cycle therefore
  // starts the next word without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      byte_cnt  <= 2'd0;
      wptr      <= TEXT_BASE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      cpu_run   <= 1'b0;
      pad_err   <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      in_ready <= (next_state != DONE);
      // Entry into DONE coincides with the last strobe. Waiting one DONE cycle
      // keeps cpu_run from overlapping mem_we.
      cpu_run  <= (state == DONE) && (next_state == DONE);
      mem_we   <= word_done && in_window;

      if (restart)        byte_cnt <= 2'd0;
      else if (word_done) byte_cnt <= 2'd0;
      else if (accept)    byte_cnt <= byte_cnt + 2'd1;

      if (restart) begin
        wptr <= TEXT_BASE;
      end else if (word_done) begin
        if (state == LOAD_TEXT && in_last) wptr <= DATA_BASE;
        else                               wptr <= sat_add4(wptr);
      end

      if (word_done && in_window) begin
        mem_addr  <= wptr;
        mem_wdata <= packed_word;
      end

      if (restart)                                       pad_err <= 1'b0;
      else if (accept && in_last && (byte_cnt != 2'd3))  pad_err <= 1'b1;

      if (restart)                     ovf_err <= 1'b0;
      else if (word_done && !in_window) ovf_err <= 1'b1;
    end
  end

endmodule
